// File: rtl/piece_move_ctrl.sv
// piece_move_ctrl
//   Owns the active piece's grid position and commits at most one move per
//   request. Requests come from rising edges of the player buttons or from
//   the gravity tick. Each decision waits one EVAL cycle so that the
//   collision flags (computed from pos_x/pos_y) have settled.
//
// Optional feature macro: AUTO_REPEAT_EN
//   When defined, a button held in HOLD re-issues its request every
//   REPEAT_CYCLES clocks. When undefined, each press gives one attempt.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   btn_up/down/left/right        debounced button levels
//   grav_tick                     one-cycle gravity request
//   up_en/down_en/left_en/right_en  move legality flags at current position
//   pos_x, pos_y                  current column / row (row 0 is the top)
//   move_pulse                    one-cycle strobe per committed move
//   move_dir                      last requested direction (0 up,1 down,2 left,3 right)
//   landed                        one-cycle strobe when a gravity drop is blocked
//   busy                          1 whenever the FSM is not IDLE
module piece_move_ctrl #(
  parameter int X_W           = 4,
  parameter int Y_W           = 6,
  parameter int X_MAX         = 9,
  parameter int Y_MAX         = 23,
  parameter int X_START       = 4,
  parameter int REPEAT_CYCLES = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           btn_up,
  input  logic           btn_down,
  input  logic           btn_left,
  input  logic           btn_right,
  input  logic           grav_tick,
  input  logic           up_en,
  input  logic           down_en,
  input  logic           left_en,
  input  logic           right_en,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic           move_pulse,
  output logic [1:0]     move_dir,
  output logic           landed,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, EVAL, HOLD} stateT;

  localparam logic [X_W-1:0] X_LAST = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_MAX);
  localparam logic [X_W-1:0] X_HOME = X_W'(X_START);

  stateT      state;
  logic       gravPend;
  logic       srcGrav;
  logic [3:0] btnPrev;
  logic [3:0] btnVec;
  logic [3:0] btnEdge;
  logic       legal;
  logic       selVld;
  logic [1:0] selDir;

`ifdef AUTO_REPEAT_EN
  localparam int CNT_W = $clog2(REPEAT_CYCLES + 1);
  logic [CNT_W-1:0] repeatCnt;
  logic             resumeVld;
  logic [1:0]       resumeDir;
`endif

  // Bit index equals the move_dir code of the button.
  assign btnVec  = {btn_right, btn_left, btn_down, btn_up};
  assign btnEdge = btnVec & ~btnPrev;

  // Legality of the latched direction: collision flag and grid boundary.
  always_comb begin
    legal = 1'b0;
    case (move_dir)
      2'd0: legal = up_en    && (pos_y != '0);
      2'd1: legal = down_en  && (pos_y != Y_LAST);
      2'd2: legal = left_en  && (pos_x != '0);
      2'd3: legal = right_en && (pos_x != X_LAST);
      default: legal = 1'b0;
    endcase
  end

  // Button selection in IDLE: a repeat interrupted by gravity resumes first,
  // then fresh edges in priority down > up > left > right.
  always_comb begin
    selVld = 1'b0;
    selDir = 2'd1;
`ifdef AUTO_REPEAT_EN
    if (resumeVld && btnVec[resumeDir]) begin
      selVld = 1'b1;
      selDir = resumeDir;
    end else
`endif
    if (btnEdge[1]) begin
      selVld = 1'b1;
      selDir = 2'd1;
    end else if (btnEdge[0]) begin
      selVld = 1'b1;
      selDir = 2'd0;
    end else if (btnEdge[2]) begin
      selVld = 1'b1;
      selDir = 2'd2;
    end else if (btnEdge[3]) begin
      selVld = 1'b1;
      selDir = 2'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      pos_x      <= X_HOME;
      pos_y      <= '0;
      move_pulse <= 1'b0;
      move_dir   <= 2'd1;
      landed     <= 1'b0;
      busy       <= 1'b0;
      gravPend   <= 1'b0;
      srcGrav    <= 1'b0;
      btnPrev    <= '0;
`ifdef AUTO_REPEAT_EN
      repeatCnt  <= '0;
      resumeVld  <= 1'b0;
      resumeDir  <= 2'd1;
`endif
    end else begin
      btnPrev    <= btnVec;
      move_pulse <= 1'b0;
      landed     <= 1'b0;
      case (state)
        IDLE: begin
          // A tick in the same cycle as a pending request merges into it.
          if (gravPend || grav_tick) begin
            gravPend <= 1'b0;
            srcGrav  <= 1'b1;
            move_dir <= 2'd1;
            state    <= EVAL;
            busy     <= 1'b1;
          end else begin
`ifdef AUTO_REPEAT_EN
            resumeVld <= 1'b0;
`endif
            if (selVld) begin
              srcGrav  <= 1'b0;
              move_dir <= selDir;
              state    <= EVAL;
              busy     <= 1'b1;
            end
          end
        end
        EVAL: begin
          if (grav_tick) gravPend <= 1'b1;
          if (legal) begin
            case (move_dir)
              2'd0: pos_y <= pos_y - Y_W'(1);
              2'd1: pos_y <= pos_y + Y_W'(1);
              2'd2: pos_x <= pos_x - X_W'(1);
              default: pos_x <= pos_x + X_W'(1);
            endcase
            move_pulse <= 1'b1;
            state      <= HOLD;
          end else if (srcGrav) begin
            // Blocked drop: the piece lands and a new one spawns at the top.
            landed <= 1'b1;
            pos_x  <= X_HOME;
            pos_y  <= '0;
            state  <= IDLE;
            busy   <= 1'b0;
          end else begin
            state <= HOLD;
          end
`ifdef AUTO_REPEAT_EN
          repeatCnt <= CNT_W'(REPEAT_CYCLES - 1);
`endif
        end
        HOLD: begin
          if (grav_tick) gravPend <= 1'b1;
          if (srcGrav || !btnVec[move_dir]) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
`ifdef AUTO_REPEAT_EN
          else if (gravPend) begin
            // Serve gravity first, remember the held direction.
            state     <= IDLE;
            busy      <= 1'b0;
            resumeVld <= 1'b1;
            resumeDir <= move_dir;
          end else if (repeatCnt <= CNT_W'(1)) begin
            // HOLD lasts REPEAT_CYCLES-1 clocks; with EVAL the period is REPEAT_CYCLES.
            state <= EVAL;
          end else begin
            repeatCnt <= repeatCnt - CNT_W'(1);
          end
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piece_move_ctrl.sv
module tb_piece_move_ctrl;

  localparam int X_W = 4, Y_W = 6, X_MAX = 9, Y_MAX = 23, X_START = 4, REPEAT_CYCLES = 8;

  logic clk = 1'b0;
  logic rst_n, btn_up, btn_down, btn_left, btn_right, grav_tick;
  logic up_en, down_en, left_en, right_en;
  logic [X_W-1:0] pos_x;
  logic [Y_W-1:0] pos_y;
  logic move_pulse, landed, busy;
  logic [1:0] move_dir;

  piece_move_ctrl #(
    .X_W(X_W), .Y_W(Y_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX),
    .X_START(X_START), .REPEAT_CYCLES(REPEAT_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .grav_tick(grav_tick),
    .up_en(up_en), .down_en(down_en), .left_en(left_en), .right_en(right_en),
    .pos_x(pos_x), .pos_y(pos_y), .move_pulse(move_pulse), .move_dir(move_dir),
    .landed(landed), .busy(busy)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nBad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Reference model: request-level view of the controller.
  //   deciding : a request was accepted and the legality decision is due next edge
  //   holding  : a move attempt finished and the request waits for button release
  int mx, my, mDir, rpt, resumeDirM;
  bit mPend, mPulse, mLand, mBusy, deciding, holding, mGrav, resume;
  bit [3:0] prevB;

  task automatic modelStep();
    bit [3:0] b, e, en;
    bit tick, ok, pendBefore;
    int sel;
    int dx[4] = '{0, 0, -1, 1};
    int dy[4] = '{-1, 1, 0, 0};
    b    = {btn_right, btn_left, btn_down, btn_up};
    en   = {right_en, left_en, down_en, up_en};
    tick = grav_tick;
    mPulse = 0;
    mLand  = 0;
    if (!rst_n) begin
      mx = X_START; my = 0; mDir = 1; mPend = 0; deciding = 0; holding = 0;
      mGrav = 0; prevB = 0; rpt = 0; resume = 0; resumeDirM = 1; mBusy = 0;
      return;
    end
    e = b & ~prevB;
    prevB = b;
    if (deciding) begin
      deciding = 0;
      mPend |= tick;
      case (mDir)
        0: ok = en[0] && (my > 0);
        1: ok = en[1] && (my < Y_MAX);
        2: ok = en[2] && (mx > 0);
        default: ok = en[3] && (mx < X_MAX);
      endcase
      rpt = REPEAT_CYCLES - 1;
      if (ok) begin
        mx += dx[mDir];
        my += dy[mDir];
        mPulse = 1;
        holding = 1;
      end else if (mGrav) begin
        mLand = 1;
        mx = X_START;
        my = 0;
      end else begin
        holding = 1;
      end
    end else if (holding) begin
      pendBefore = mPend;
      mPend |= tick;
      if (mGrav || !b[mDir]) holding = 0;
`ifdef AUTO_REPEAT_EN
      else if (pendBefore) begin
        holding = 0;
        resume = 1;
        resumeDirM = mDir;
      end else if (rpt <= 1) begin
        holding = 0;
        deciding = 1;
      end else rpt--;
`endif
    end else begin
      sel = -1;
      if (mPend || tick) begin
        mPend = 0;
        mGrav = 1;
        mDir = 1;
        deciding = 1;
      end else begin
`ifdef AUTO_REPEAT_EN
        if (resume && b[resumeDirM]) sel = resumeDirM;
        resume = 0;
`endif
        if (sel < 0) begin
          if (e[1]) sel = 1;
          else if (e[0]) sel = 0;
          else if (e[2]) sel = 2;
          else if (e[3]) sel = 3;
        end
        if (sel >= 0) begin
          mGrav = 0;
          mDir = sel;
          deciding = 1;
        end
      end
    end
    mBusy = deciding || holding;
  endtask

  // One clock: model advances with the inputs seen at the edge, outputs
  // are compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    modelStep();
    #1;
    chk("pos_x", pos_x, mx);
    chk("pos_y", pos_y, my);
    chk("move_pulse", move_pulse, mPulse);
    chk("move_dir", move_dir, mDir);
    chk("landed", landed, mLand);
    chk("busy", busy, mBusy);
  endtask

  task automatic setBtn(input int d, input logic v);
    case (d)
      0: btn_up = v;
      1: btn_down = v;
      2: btn_left = v;
      default: btn_right = v;
    endcase
  endtask

  task automatic press(input int d, input int holdCycles);
    setBtn(d, 1'b1);
    repeat (holdCycles) step();
    setBtn(d, 1'b0);
    repeat (3) step();
  endtask

  task automatic gravDrop();
    grav_tick = 1'b1;
    step();
    grav_tick = 1'b0;
    repeat (4) step();
  endtask

  int pulseAt[$];

  initial begin
    rst_n = 1'b0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    grav_tick = 0; up_en = 1; down_en = 1; left_en = 1; right_en = 1;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("rst_pos_x", pos_x, 4);
    chk("rst_pos_y", pos_y, 0);
    chk("rst_strobes", {move_pulse, landed}, 0);
    chk("rst_busy", busy, 0);

    // Left press: move two clocks after the press, no further move while held.
    setBtn(2, 1'b1);
    step();
    chk("left_no_early_pulse", move_pulse, 0);
    step();
    chk("left_pulse", move_pulse, 1);
    chk("left_x", pos_x, 3);
    chk("left_dir", move_dir, 2);
    repeat (5) step();
    chk("left_held_x", pos_x, 3);
    setBtn(2, 1'b0);
    repeat (3) step();

    // Walk to the right edge, then try past it twice.
    repeat (6) press(3, 2);
    chk("right_edge_x", pos_x, 9);
    press(3, 3);
    chk("right_bound_x", pos_x, 9);
    press(3, 3);
    chk("right_bound_again_x", pos_x, 9);

    // Reach (6,12) and land with the drop blocked.
    repeat (3) press(2, 2);
    repeat (12) gravDrop();
    chk("pre_land_x", pos_x, 6);
    chk("pre_land_y", pos_y, 12);
    down_en = 1'b0;
    grav_tick = 1'b1;
    step();
    grav_tick = 1'b0;
    step();
    chk("land_pulse", landed, 1);
    chk("land_no_move", move_pulse, 0);
    chk("land_x", pos_x, 4);
    chk("land_y", pos_y, 0);
    down_en = 1'b1;
    repeat (3) step();

    // Gravity and up edge together at y=5: only the drop happens; two ticks
    // around the following HOLD merge into one more drop.
    repeat (5) gravDrop();
    grav_tick = 1'b1;
    btn_up = 1'b1;
    step();
    grav_tick = 1'b0;
    step();
    chk("grav_wins_y", pos_y, 6);
    grav_tick = 1'b1;
    step();
    step();
    grav_tick = 1'b0;
    repeat (6) step();
    chk("merged_ticks_y", pos_y, 7);
    btn_up = 1'b0;
    repeat (3) step();

`ifdef AUTO_REPEAT_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    btn_down = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (move_pulse) pulseAt.push_back(i);
    end
    chk("repeat_count", pulseAt.size(), 5);
    for (int i = 0; i < 5 && i < pulseAt.size(); i++) chk("repeat_clock", pulseAt[i], 2 + 8 * i);
    chk("repeat_y", pos_y, 5);
    rst_n = 1'b0;
    step();
    chk("midhold_rst_x", pos_x, 4);
    chk("midhold_rst_y", pos_y, 0);
    rst_n = 1'b1;
    btn_down = 1'b0;
    step();
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(3) == 0) btn_up = ~btn_up;
      if ($urandom_range(3) == 0) btn_down = ~btn_down;
      if ($urandom_range(3) == 0) btn_left = ~btn_left;
      if ($urandom_range(3) == 0) btn_right = ~btn_right;
      grav_tick = ($urandom_range(7) == 0);
      up_en    = ($urandom_range(3) != 0);
      down_en  = ($urandom_range(3) != 0);
      left_en  = ($urandom_range(3) != 0);
      right_en = ($urandom_range(3) != 0);
      rst_n    = ($urandom_range(199) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
